// File: rtl/pht_port_sched.sv
// Single-port scheduler for the 2-bit pattern history table: sweeps every entry
// to INIT_VAL after reset/flush, then arbitrates the port between lookups and RMW updates.
module pht_port_sched #(
  parameter int               ADDR_W       = 8,
  parameter int               CTR_W        = 2,
  parameter logic [CTR_W-1:0] INIT_VAL     = 2'b01,
  parameter int               STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_req,
  output logic              init_busy,
  input  logic              lookup_valid,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              lookup_ready,
  output logic              pred_valid,
  output logic [CTR_W-1:0]  pred_ctr,
  output logic              pred_taken,
  input  logic              update_valid,
  input  logic [ADDR_W-1:0] update_addr,
  input  logic              update_taken,
  output logic              update_ready,
  output logic [ADDR_W-1:0] table_addr,
  output logic              table_we,
  output logic [CTR_W-1:0]  table_wdata,
  input  logic [CTR_W-1:0]  table_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {INIT, IDLE, UPD_WR} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] idx, idx_next;
  logic [SW-1:0]     starve_cnt, starve_next;
  logic [ADDR_W-1:0] upd_addr;
  logic              upd_taken;
  logic              at_limit, idle_open;
  logic              lookup_grant, update_grant;
  logic [ADDR_W-1:0] addr_c;
  logic              we_c;
  logic [CTR_W-1:0]  wdata_c;
  logic [CTR_W-1:0]  ctr_bumped;

  // Readiness never looks at its own valid, so requesters may wait on ready.
  assign at_limit     = (starve_cnt == LIMIT);
  assign idle_open    = (state == IDLE) && !flush_req;
  assign lookup_ready = idle_open && !at_limit;
  assign update_ready = idle_open && (at_limit || !lookup_valid);
  assign lookup_grant = lookup_valid && lookup_ready;
  assign update_grant = update_valid && update_ready;

  always_comb begin
    ctr_bumped = table_rdata;
    if (upd_taken) begin
      if (table_rdata != {CTR_W{1'b1}}) ctr_bumped = table_rdata + 1'b1;
    end else begin
      if (table_rdata != '0) ctr_bumped = table_rdata - 1'b1;
    end
  end

  always_comb begin
    state_next  = state;
    idx_next    = idx;
    starve_next = starve_cnt;
    addr_c      = '0;
    we_c        = 1'b0;
    wdata_c     = '0;
    case (state)
      INIT: begin
        addr_c   = idx;
        we_c     = 1'b1;
        wdata_c  = INIT_VAL;
        idx_next = idx + 1'b1;
        if (idx == {ADDR_W{1'b1}}) state_next = IDLE;
      end
      IDLE: begin
        addr_c = update_grant ? update_addr : lookup_addr;
        if (update_grant) begin
          starve_next = '0;
        end else if (update_valid && !at_limit) begin
          starve_next = starve_cnt + 1'b1;
        end
        if (flush_req) begin
          state_next = INIT;
          idx_next   = '0;
        end else if (update_grant) begin
          state_next = UPD_WR;
        end
      end
      UPD_WR: begin
        // The write always lands before a flush sweep begins.
        addr_c     = upd_addr;
        we_c       = 1'b1;
        wdata_c    = ctr_bumped;
        state_next = flush_req ? INIT : IDLE;
        idx_next   = '0;
      end
      default: begin
        state_next = INIT;
        idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      idx        <= '0;
      starve_cnt <= '0;
      upd_addr   <= '0;
      upd_taken  <= 1'b0;
      pred_valid <= 1'b0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      starve_cnt <= starve_next;
      pred_valid <= lookup_grant;
      if (update_grant) begin
        upd_addr  <= update_addr;
        upd_taken <= update_taken;
      end
    end
  end

  // Port drive is held quiet while reset is asserted, even though the FSM sits in INIT.
  assign table_we    = rst_n & we_c;
  assign table_addr  = rst_n ? addr_c : '0;
  assign table_wdata = rst_n ? wdata_c : '0;

  assign init_busy  = (state == INIT);
  assign pred_ctr   = pred_valid ? table_rdata : '0;
  assign pred_taken = pred_ctr[CTR_W-1];

endmodule

// File: tb/tb_pht_port_sched.sv
// Bench for pht_port_sched: a table RAM model, a spec-level reference model checked
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_pht_port_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush_req = 1'b0;
  logic       init_busy;
  logic       lookup_valid = 1'b0;
  logic [7:0] lookup_addr = '0;
  logic       lookup_ready;
  logic       pred_valid;
  logic [1:0] pred_ctr;
  logic       pred_taken;
  logic       update_valid = 1'b0;
  logic [7:0] update_addr = '0;
  logic       update_taken = 1'b0;
  logic       update_ready;
  logic [7:0] table_addr;
  logic       table_we;
  logic [1:0] table_wdata;
  logic [1:0] table_rdata = '0;

  pht_port_sched dut (
    .clk(clk), .rst_n(rst_n), .flush_req(flush_req), .init_busy(init_busy),
    .lookup_valid(lookup_valid), .lookup_addr(lookup_addr), .lookup_ready(lookup_ready),
    .pred_valid(pred_valid), .pred_ctr(pred_ctr), .pred_taken(pred_taken),
    .update_valid(update_valid), .update_addr(update_addr), .update_taken(update_taken),
    .update_ready(update_ready), .table_addr(table_addr), .table_we(table_we),
    .table_wdata(table_wdata), .table_rdata(table_rdata)
  );

  always #5 clk = ~clk;

  // Physical table: synchronous read, write visible to the next read.
  logic [1:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 2'b10;
  always @(posedge clk) begin
    if (table_we) mem[table_addr] <= table_wdata;
    table_rdata <= mem[table_addr];
  end

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what the table should hold and what the port should be doing.
  int         ref_tbl [256];
  bit         m_init, m_busy, m_pp;
  int         m_idx, m_starve, m_upd_addr, m_upd_taken, m_pv;
  bit         lk_acc, up_acc;
  int         init_run = 0, last_init = 0;
  logic [9:0] wlog [$];
  logic [1:0] plog [$];

  function automatic int sat(input int v, input int taken);
    if (taken != 0) return (v >= 3) ? 3 : v + 1;
    return (v <= 0) ? 0 : v - 1;
  endfunction

  function automatic void start_init();
    m_init = 1'b1;
    m_idx  = 0;
    for (int i = 0; i < 256; i++) ref_tbl[i] = 1;
  endfunction

  always @(negedge clk) begin
    bit e_lr, e_ur, lg, ug;
    int nv;
    lk_acc = 1'b0;
    up_acc = 1'b0;
    if (!rst_n) begin
      start_init();
      m_busy = 0; m_pp = 0; m_starve = 0; init_run = 0;
    end else begin
      chk("pred_valid", pred_valid, m_pp);
      if (m_pp) begin
        chk("pred_ctr", pred_ctr, m_pv);
        chk("pred_taken", pred_taken, m_pv / 2);
        plog.push_back(pred_ctr);
      end
      chk("init_busy", init_busy, m_init);
      if (init_busy) init_run++;
      else if (init_run != 0) begin last_init = init_run; init_run = 0; end
      m_pp = 0;
      if (m_init) begin
        chk("init_we", table_we, 1);
        chk("init_addr", table_addr, m_idx);
        chk("init_wdata", table_wdata, 1);
        chk("init_lready", lookup_ready, 0);
        chk("init_uready", update_ready, 0);
        m_idx++;
        if (m_idx == 256) m_init = 0;
      end else if (m_busy) begin
        nv = sat(ref_tbl[m_upd_addr], m_upd_taken);
        chk("upd_we", table_we, 1);
        chk("upd_addr", table_addr, m_upd_addr);
        chk("upd_wdata", table_wdata, nv);
        chk("upd_lready", lookup_ready, 0);
        chk("upd_uready", update_ready, 0);
        wlog.push_back({table_addr, table_wdata});
        ref_tbl[m_upd_addr] = nv;
        m_busy = 0;
        if (flush_req) start_init();
      end else begin
        e_lr = !flush_req && (m_starve != 4);
        e_ur = !flush_req && ((m_starve == 4) || !lookup_valid);
        chk("lookup_ready", lookup_ready, e_lr);
        chk("update_ready", update_ready, e_ur);
        chk("idle_we", table_we, 0);
        lg = lookup_valid && e_lr;
        ug = update_valid && e_ur;
        if (lg) chk("lookup_addr_out", table_addr, lookup_addr);
        if (ug) chk("update_addr_out", table_addr, update_addr);
        if (ug) m_starve = 0;
        else if (update_valid && m_starve < 4) m_starve++;
        if (flush_req) start_init();
        else if (lg) begin
          m_pp = 1; m_pv = ref_tbl[lookup_addr]; lk_acc = 1'b1;
        end else if (ug) begin
          m_busy = 1; m_upd_addr = update_addr; m_upd_taken = update_taken; up_acc = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init();
    int n = 0;
    while (init_busy && n < 600) begin tick(); n++; end
    if (init_busy) chk("init_timeout", 0, 1);
    tick();
  endtask

  task automatic lookup(input logic [7:0] a, output logic [1:0] v);
    int n = 0;
    lookup_valid = 1'b1;
    lookup_addr  = a;
    do begin tick(); n++; end while (!lk_acc && n < 50);
    lookup_valid = 1'b0;
    if (!lk_acc) chk("lookup_timeout", 0, 1);
    tick();
    v = (plog.size() > 0) ? plog[$] : 2'bxx;
  endtask

  task automatic update(input logic [7:0] a, input logic t);
    int n = 0;
    update_valid = 1'b1;
    update_addr  = a;
    update_taken = t;
    do begin tick(); n++; end while (!up_acc && n < 50);
    update_valid = 1'b0;
    if (!up_acc) chk("update_timeout", 0, 1);
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_we"}, table_we, 0);
    chk({tag, "_addr"}, table_addr, 0);
    chk({tag, "_wdata"}, table_wdata, 0);
    chk({tag, "_lready"}, lookup_ready, 0);
    chk({tag, "_uready"}, update_ready, 0);
    chk({tag, "_pred_valid"}, pred_valid, 0);
    chk({tag, "_pred_ctr"}, pred_ctr, 0);
    chk({tag, "_init_busy"}, init_busy, 1);
  endtask

  initial begin
    logic [1:0] v;
    int nl, n;
    repeat (3) tick();
    reset_outputs("rst");
    rst_n = 1'b1;
    wait_init();
    chk("init_len", last_init, 256);

    lookup(8'h80, v);
    chk("lk80_ctr", v, 1);
    chk("lk80_taken", v[1], 0);

    wlog.delete();
    repeat (3) update(8'h05, 1'b1);
    lookup(8'h05, v);
    chk("sat_w0", wlog[0], {8'h05, 2'b10});
    chk("sat_w1", wlog[1], {8'h05, 2'b11});
    chk("sat_w2", wlog[2], {8'h05, 2'b11});
    chk("sat_ctr", v, 3);
    repeat (4) update(8'h05, 1'b0);
    lookup(8'h05, v);
    chk("dec_w6", wlog[6], {8'h05, 2'b00});
    chk("dec_ctr", v, 0);

    lookup_valid = 1'b1; lookup_addr = 8'h82;
    update_valid = 1'b1; update_addr = 8'h82; update_taken = 1'b1;
    tick();
    chk("same_lk_wins", lk_acc, 1);
    chk("same_up_waits", up_acc, 0);
    lookup_valid = 1'b0;
    tick();
    chk("same_old_val", plog[$], 1);
    chk("same_up_granted", up_acc, 1);
    update_valid = 1'b0;
    tick();
    chk("same_write", wlog[$], {8'h82, 2'b10});
    lookup(8'h82, v);
    chk("same_new_val", v, 2);

    lookup_valid = 1'b1;
    update_valid = 1'b1; update_addr = 8'h33; update_taken = 1'b0;
    for (int r = 0; r < 2; r++) begin
      nl = 0; n = 0;
      do begin
        tick(); n++;
        if (lk_acc) nl++;
        lookup_addr = 8'($urandom_range(0, 255));
      end while (!up_acc && n < 20);
      chk("starve_lookups", nl, 4);
    end
    lookup_valid = 1'b0;
    update_valid = 1'b0;
    tick(); tick();

    update(8'h10, 1'b1);
    update_valid = 1'b1; update_addr = 8'h10; update_taken = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!up_acc && n < 50);
    flush_req = 1'b1;
    update_valid = 1'b0;
    tick();
    flush_req = 1'b0;
    chk("flush_write", wlog[$], {8'h10, 2'b11});
    chk("flush_idx0", table_addr, 0);
    chk("flush_busy", init_busy, 1);
    last_init = 0;
    wait_init();
    chk("flush_init_len", last_init, 256);
    lookup(8'h10, v);
    chk("flush_reinit", v, 1);

    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    repeat (100) tick();
    chk("mid_init_idx", table_addr, 100);
    rst_n = 1'b0;
    #1;
    reset_outputs("midrst");
    tick(); tick();
    last_init = 0;
    rst_n = 1'b1;
    wait_init();
    chk("restart_init_len", last_init, 256);

    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!update_valid || up_acc) begin
        update_valid = ($urandom_range(0, 2) == 0);
        update_addr  = 8'($urandom_range(0, 15));
        update_taken = 1'($urandom_range(0, 1));
      end
      lookup_valid = 1'($urandom_range(0, 1));
      lookup_addr  = 8'($urandom_range(0, 15));
      flush_req    = ($urandom_range(0, 399) == 0);
    end
    lookup_valid = 1'b0;
    update_valid = 1'b0;
    flush_req    = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
